color_fade_sequencer: RTL
=========================

COLOR_FADE_SEQUENCER -- requirements
Module: color_fade_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 500_000, clocks per fade step (10 ms at 50 MHz).
REQ-002 SHALL have parameter HOLD_STEPS, default 100, steps held at each palette colour once reached.
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  in  1  run sequencer when high.
REQ-006 SHALL have port wr_en  in  1  palette write strobe.
REQ-007 SHALL have port wr_addr  in  2  palette entry 0..3.
REQ-008 SHALL have port wr_data  in  24  GRB colour, G[23:16] R[15:8] B[7:0].
REQ-009 SHALL have port color_out  out  24  current GRB colour for the WS2812 serializer stage.
REQ-010 SHALL have port color_valid  out  1  color_out holds a new, unconsumed colour.
REQ-011 SHALL have port color_ready  in  1  downstream accepts color_out (frame boundary).
REQ-012 SHALL have port pal_idx  out  2  index of the palette entry currently targeted.
REQ-013 SHALL have port at_target  out  1  high when color_out equals palette[pal_idx].

Function
REQ-014 SHALL implement states IDLE, FADE, HOLD, ADVANCE.
REQ-015 IDLE -> FADE when enable=1; any state -> IDLE when enable=0, with colour and pal_idx frozen.
REQ-016 Step tick: counter 0..STEP_CYCLES-1, tick on terminal count; counter cleared in IDLE.
REQ-017 FADE, on tick: each 8-bit channel moves 1 LSB toward its target (+1 if below, -1 if above, unchanged if equal); no wrap, no overshoot.
REQ-018 FADE -> HOLD in the cycle the updated colour equals target; hold counter cleared.
REQ-019 HOLD: count ticks; after HOLD_STEPS ticks -> ADVANCE.
REQ-020 ADVANCE: pal_idx increments modulo 4 (3 -> 0), single cycle, -> FADE.
REQ-021 Every change of color_out SHALL set color_valid=1 in the same cycle the register updates.
REQ-022 color_valid clears on the cycle color_valid && color_ready; color_out stable while color_valid && !color_ready.
REQ-023 Backpressure: a tick arriving while color_valid && !color_ready SHALL be held pending (tick counter stops at terminal) and applied the cycle after acceptance; no step is lost.
REQ-024 color_valid SHALL never deassert without acceptance, including when enable drops.
REQ-025 Palette write takes effect next cycle; write to entry pal_idx retargets the fade immediately; in HOLD, a target mismatch -> FADE.
REQ-026 wr_en and state advance in the same cycle: write lands, advance uses the new pal_idx and sees the written value next cycle.
REQ-027 at_target is combinational compare of color_out and palette[pal_idx].

Reset
REQ-028 Asserting rst SHALL immediately force: state IDLE, color_out 0, color_valid 0, pal_idx 0, all palette entries 0, counters 0.
REQ-029 Reset mid-fade or mid-handshake SHALL discard pending ticks; first post-reset step occurs a full STEP_CYCLES after enable.

Structure
REQ-030 State encoding, GRB field offsets and palette depth (4) SHALL live in a shared ws2812 package used by this block and the serializer.
REQ-031 Per-channel step logic SHALL be one sub-module, channel_ramp (8-bit current, 8-bit target -> next value, equal flag), instantiated three times.

Verification (bench: STEP_CYCLES=4, HOLD_STEPS=2)
REQ-032 Reset, palette[0]=0x030000, enable, color_ready=1 -> color_out 0x010000, 0x020000, 0x030000 at 4-clock spacing, then HOLD 8 clocks, pal_idx -> 1.
REQ-033 Palette[1]=0x000000 from 0x030000 -> down-ramp 0x020000, 0x010000, 0x000000, no underflow; palette[3] reached -> pal_idx wraps to 0.
REQ-034 color_ready=0 for 20 clocks after first valid -> color_out stable, color_valid high, no step lost; release -> next step 1 clock after acceptance.
REQ-035 Write palette[pal_idx]=0xFFFFFF while in HOLD at 0x030000 -> FADE, next step 0x040101.
REQ-036 rst pulse mid-fade at 0x020000 -> color_out 0, color_valid 0, pal_idx 0 in same cycle; palette reads 0.
REQ-037 enable low mid-FADE with unaccepted colour -> color_valid stays until color_ready, no further steps until enable returns.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 colour pipeline: GRB layout, palette size and
// the fade sequencer state encoding.
package ws2812_pkg;

    localparam int COLOR_W   = 24;
    localparam int CHAN_W    = 8;
    localparam int NUM_CHAN  = 3;
    localparam int G_LSB     = 16;
    localparam int R_LSB     = 8;
    localparam int B_LSB     = 0;
    localparam int PAL_DEPTH = 4;
    localparam int PAL_AW    = 2;

    typedef logic [COLOR_W-1:0] grb_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FADE    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_ADVANCE = 2'd3
    } seq_state_t;

    // Channel 0 is G, 1 is R, 2 is B, matching the on-wire GRB order.
    function automatic int chan_lsb(input int ch);
        case (ch)
            0:       return G_LSB;
            1:       return R_LSB;
            default: return B_LSB;
        endcase
    endfunction

endpackage

// File: rtl/channel_ramp.sv
// One 8-bit colour channel: move one LSB toward the target, saturating at the target.
module channel_ramp
    import ws2812_pkg::*;
(
    input  logic [CHAN_W-1:0] cur,
    input  logic [CHAN_W-1:0] target,
    output logic [CHAN_W-1:0] step_val,
    output logic              reached
);

    always_comb begin
        step_val = cur;
        if (cur < target) begin
            step_val = cur + CHAN_W'(1);
        end else if (cur > target) begin
            step_val = cur - CHAN_W'(1);
        end
    end

    assign reached = (step_val == target);

endmodule

// File: rtl/color_fade_sequencer.sv
// Cycles a colour through a 4-entry GRB palette: ramp toward each entry one LSB per step,
// hold there, then advance to the next entry, offering each new colour to the serializer.
module color_fade_sequencer
    import ws2812_pkg::*;
#(
    parameter int STEP_CYCLES = 500_000,
    parameter int HOLD_STEPS  = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               wr_en,
    input  logic [PAL_AW-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic [COLOR_W-1:0] color_out,
    output logic               color_valid,
    input  logic               color_ready,
    output logic [PAL_AW-1:0]  pal_idx,
    output logic               at_target,
    output seq_state_t         dbg_state
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    seq_state_t          state;
    seq_state_t          next_state;
    logic                in_fade;
    logic                in_hold;
    logic                in_advance;

    grb_t                palette [PAL_DEPTH];
    grb_t                target;
    grb_t                ramp_next;
    logic [NUM_CHAN-1:0] reached;

    logic [CW-1:0]       step_cnt;
    logic [HW-1:0]       hold_cnt;
    logic                term;
    logic                tick;
    logic                step_apply;
    logic                fade_done;
    logic                hold_done;

    assign target    = palette[pal_idx];
    assign at_target = (color_out == target);

    for (genvar ch = 0; ch < NUM_CHAN; ch++) begin : g_chan
        channel_ramp u_ramp (
            .cur      (color_out[chan_lsb(ch) +: CHAN_W]),
            .target   (target[chan_lsb(ch) +: CHAN_W]),
            .step_val (ramp_next[chan_lsb(ch) +: CHAN_W]),
            .reached  (reached[ch])
        );
    end

    // A tick is suppressed while a colour is still offered, so the step lands the cycle
    // after the serializer takes the previous one.
    assign term       = (step_cnt == CW'(STEP_CYCLES - 1));
    assign tick       = enable && (state != ST_IDLE) && term && !color_valid;
    assign step_apply = tick && in_fade;
    assign fade_done  = step_apply ? (&reached) : at_target;
    assign hold_done  = tick && (hold_cnt == HW'(HOLD_STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    next_state = ST_FADE;
                ST_FADE:    if (fade_done) next_state = ST_HOLD;
                ST_HOLD: begin
                    if (!at_target) begin
                        next_state = ST_FADE;
                    end else if (hold_done) begin
                        next_state = ST_ADVANCE;
                    end
                end
                ST_ADVANCE: next_state = ST_FADE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dbg_state  = state;
        in_fade    = (state == ST_FADE);
        in_hold    = (state == ST_HOLD);
        in_advance = (state == ST_ADVANCE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (state == ST_IDLE) begin
            step_cnt <= '0;
        end else if (term) begin
            if (!color_valid) begin
                step_cnt <= '0;
            end
        end else begin
            step_cnt <= step_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (!in_hold) begin
            hold_cnt <= '0;
        end else if (tick) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                palette[i] <= '0;
            end
        end else if (wr_en) begin
            palette[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_idx <= '0;
        end else if (in_advance && enable) begin
            pal_idx <= pal_idx + PAL_AW'(1);
        end
    end

    // Handshake: color_out/color_valid are a valid/ready source. color_valid rises with every
    // change of color_out, the colour is consumed on any cycle with color_valid && color_ready,
    // and while offered color_out holds and color_valid never drops without that acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_out   <= '0;
            color_valid <= 1'b0;
        end else if (step_apply && (ramp_next != color_out)) begin
            color_out   <= ramp_next;
            color_valid <= 1'b1;
        end else if (color_valid && color_ready) begin
            color_valid <= 1'b0;
        end
    end

endmodule
